// File: rtl/mux4_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_sel_pkg
//  Purpose  : Shared constants, FSM state type and the rotate-priority pick
//             function for the 4:1 mux select arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mux4_sel_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {found, idx}. The scan starts at ptr and wraps modulo N_CH.
  // Iterating from the farthest offset down lets the nearest hit win.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_CH-1:0]  req,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W:0]   res;
    res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_sel_arb_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational rotate-priority encoder; finds the first active
//             request at or after ptr (wrapping 3 -> 0).
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
  import mux4_sel_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  assign {found, idx} = rr_pick(req, ptr);

endmodule
`default_nettype wire

// File: rtl/mux4_sel_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_sel_arb
//  Purpose  : Round-robin burst arbiter producing the select for a 4:1 data
//             mux, with a valid/ready handshake toward the consumer.
//             Optional macro MUX4_SEL_LOCK_EN adds the lock input, which keeps
//             the current grant past the burst limit.
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_sel_arb
  import mux4_sel_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             out_ready,
`ifdef MUX4_SEL_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gnt,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(MAX_BURST - 1);
  localparam logic [N_CH-1:0]  c_one  = {{(N_CH-1){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel,   w_sel_nxt;
  logic [N_CH-1:0]   r_gnt,   w_gnt_nxt;
  logic [SEL_W-1:0]  r_ptr,   w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;

  logic              w_lock;
  logic              w_xfer;
  logic              w_rel_a;
  logic              w_rel_b;
  logic              w_release;
  logic [N_CH-1:0]   w_pick_req;
  logic [SEL_W-1:0]  w_pick_ptr;
  logic              w_found;
  logic [SEL_W-1:0]  w_idx;

`ifdef MUX4_SEL_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // Outputs derive from the registered state so reset clears them at once.
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_valid = (r_state == GRANT) & req[r_sel];
  assign busy      = (r_state != IDLE);

  // Release conditions and the request/pointer fed to the shared picker.
  always_comb begin
    w_xfer     = out_valid & out_ready;
    w_rel_b    = ~req[r_sel];
    w_rel_a    = w_xfer & (r_cnt == c_last) & ~w_lock;
    w_release  = (r_state == GRANT) & (w_rel_a | w_rel_b);
    w_pick_req = req;
    w_pick_ptr = r_ptr;
    if (r_state == GRANT) begin
      w_pick_ptr = r_sel + SEL_W'(1);
      if (w_rel_b) w_pick_req[r_sel] = 1'b0;
    end
  end

  rr_pick4 u_pick (
    .req   (w_pick_req),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Next-state logic: grant on entry, count transfers, rotate on release.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_idx;
          w_gnt_nxt   = c_one << w_idx;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_sel + SEL_W'(1);
          w_cnt_nxt = '0;
          if (w_found) begin
            w_sel_nxt = w_idx;
            w_gnt_nxt = c_one << w_idx;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (w_xfer && (r_cnt != c_last)) begin
          // Saturation at c_last only matters while lock holds the grant.
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and select registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux4_sel_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_sel_arb
//  Purpose  : Self-checking bench for mux4_sel_arb with a transfer scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_sel_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
`ifdef MUX4_SEL_LOCK_EN
  logic       lock;
`endif
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Expected select value of each accepted transfer, in order.
  logic [1:0] sb[$];

  mux4_sel_arb #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
`ifdef MUX4_SEL_LOCK_EN
    .lock      (lock),
`endif
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted transfer must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got sel %0d expected none at %0t", sel, $time);
      end else begin
        logic [1:0] e;
        logic [3:0] one;
        e   = sb.pop_front();
        one = 4'b0001;
        chk("xfer_sel", 32'(sel), 32'(e));
        chk("xfer_gnt", 32'(gnt), 32'(one << e));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_n(input logic [1:0] s, input int n);
    repeat (n) sb.push_back(s);
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Asserts reset without a clock edge and checks the outputs clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",   32'(gnt),       32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_sel",   32'(sel),       32'd0);
    req       = 4'b0000;
    out_ready = 1'b0;
`ifdef MUX4_SEL_LOCK_EN
    lock      = 1'b0;
`endif
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst_n     = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
`ifdef MUX4_SEL_LOCK_EN
    lock      = 1'b0;
`endif
    #1;
    do_reset();

    // Rotation: four transfers per channel, wrap 3 -> 0, no idle bubble.
    req = 4'b1111; out_ready = 1'b1;
    push_n(2'd0, 4); push_n(2'd1, 4); push_n(2'd2, 4); push_n(2'd3, 4); push_n(2'd0, 4);
    cyc(21);
    chk_drained("rotate_drained");
    chk("rotate_busy", 32'(busy), 32'd1);
    do_reset();   // mid-GRANT reset

    // After reset priority restarts at channel 0.
    req = 4'b1111;
    cyc(1);
    chk("post_rst_sel", 32'(sel), 32'd0);
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    do_reset();

    // Backpressure: grant held with no rotation while stalled.
    req = 4'b0101; out_ready = 1'b0;
    cyc(11);
    chk("bp_sel",   32'(sel),       32'd0);
    chk("bp_gnt",   32'(gnt),       32'b0001);
    chk("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    push_n(2'd0, 4); push_n(2'd2, 4);
    cyc(8);
    chk_drained("bp_drained");
    chk("bp_wrap_sel", 32'(sel), 32'd0);
    do_reset();

    // Drop: granted ch2 drops after one transfer, ch3 takes over next cycle.
    req = 4'b1100; out_ready = 1'b1;
    push_n(2'd2, 1);
    cyc(2);
    req = 4'b1000; out_ready = 1'b0;
    cyc(1);
    chk("drop_sel",   32'(sel),       32'd3);
    chk("drop_gnt",   32'(gnt),       32'b1000);
    chk("drop_valid", 32'(out_valid), 32'd1);
    chk_drained("drop_drained");
    do_reset();

    // Sole requester re-granted across burst limits with no gap.
    req = 4'b0010; out_ready = 1'b1;
    push_n(2'd1, 10);
    cyc(11);
    chk_drained("sole_drained");
    chk("sole_sel", 32'(sel), 32'd1);
    do_reset();

    // Idle after the last requester leaves.
    req = 4'b0001; out_ready = 1'b0;
    cyc(2);
    req = 4'b0000;
    cyc(2);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt",  32'(gnt),  32'd0);
    do_reset();

`ifdef MUX4_SEL_LOCK_EN
    // Lock keeps ch0 past the burst limit; dropping lock rotates to ch1.
    req = 4'b1111; out_ready = 1'b1; lock = 1'b1;
    push_n(2'd0, 21); push_n(2'd1, 1);
    cyc(21);
    lock = 1'b0;
    cyc(2);
    chk_drained("lock_drained");
    chk("lock_sel", 32'(sel), 32'd1);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
